// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: pipeline sequencing controller for a 5-stage MIPS-style core.
// Holds the pipeline while the EX/MEM memory op runs its req/ack handshake with
// a multi-cycle data memory, and inserts a load-use bubble between ID/EX and IF/ID.
// Stage enables, flush and bubble are combinational; all memory-side outputs are registered.
module mem_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        MReadreg,
  input  logic        MWritereg,
  input  logic [31:0] ALUreg,
  input  logic [31:0] WriteDataOut,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        IDEX_MRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        IDEX_flush,
  output logic        MEMWB_bubble,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Last counter value of the ACCESS window; reaching it without an ack aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_load_data;
  logic             r_mem_err;

  logic             w_memop;
  logic             w_hazard;
  logic             w_timeout;

  assign w_memop   = MReadreg | MWritereg;
  assign w_timeout = (r_cnt == CNT_LAST);
  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_hazard  = IDEX_MRead & (IDEX_Rt != 5'd0) &
                     ((IDEX_Rt == IFID_Rs) | (IDEX_Rt == IFID_Rt));

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign load_data = r_load_data;
  assign mem_err   = r_mem_err;

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCESS on a memory op, ACCESS -> DONE on ack or timeout, DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_ack || w_timeout) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage enables, ID/EX flush and MEM/WB bubble; memory stall outranks the load-use hazard.
  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    EXMEMWrite   = 1'b1;
    IDEX_flush   = 1'b0;
    MEMWB_bubble = 1'b0;
    if (rst) begin
      PCWrite      = 1'b1;
      MEMWB_bubble = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEMWrite   = 1'b0;
            MEMWB_bubble = 1'b1;
          end else if (w_hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEX_flush = 1'b1;
          end else begin
            PCWrite = 1'b1;
          end
        end
        S_ACCESS: begin
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          EXMEMWrite   = 1'b0;
          MEMWB_bubble = 1'b1;
        end
        S_DONE: begin
          // Completed op advances into MEM/WB; everything moves.
          PCWrite = 1'b1;
        end
        default: begin
          PCWrite = 1'b1;
        end
      endcase
    end
  end

  // Memory handshake datapath: launch request, count wait cycles, capture read data or abort.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt       <= CNT_ZERO;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            r_mem_addr  <= ALUreg;
            r_mem_wdata <= WriteDataOut;
            // A load+store combination is issued as a store.
            r_mem_we    <= MWritereg;
            r_mem_req   <= 1'b1;
            r_cnt       <= CNT_ZERO;
          end else begin
            r_mem_req <= 1'b0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (mem_ack) begin
            // Ack takes precedence over a coincident timeout.
            if (!r_mem_we) begin
              r_load_data <= mem_rdata;
            end
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_mem_err   <= 1'b1;
            r_load_data <= 32'd0;
            r_mem_req   <= 1'b0;
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        S_DONE: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed testbench for mem_stall_ctrl with TIMEOUT=8.
module tb_mem_stall_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        MReadreg, MWritereg;
  logic [31:0] ALUreg, WriteDataOut;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        IDEX_MRead;
  logic [4:0]  IDEX_Rt, IFID_Rs, IFID_Rt;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic        IDEX_flush, MEMWB_bubble, mem_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mem_stall_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clock(clock), .rst(rst),
    .MReadreg(MReadreg), .MWritereg(MWritereg),
    .ALUreg(ALUreg), .WriteDataOut(WriteDataOut),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .IDEX_MRead(IDEX_MRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_data(load_data),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .IDEX_flush(IDEX_flush),
    .MEMWB_bubble(MEMWB_bubble), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEX_flush, MEMWB_bubble as one vector.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEX_flush, MEMWB_bubble},
        {26'd0, exp});
  endtask

  initial begin
    rst = 1'b1; MReadreg = 1'b0; MWritereg = 1'b0;
    ALUreg = 32'd0; WriteDataOut = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    IDEX_MRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    tick(); tick();

    // Reset state
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk_ctl("rst_ctl", 6'b111100);
    MReadreg = 1'b1; #1;
    chk_ctl("rst_ctl_memop", 6'b111100);
    MReadreg = 1'b0;
    tick();
    rst = 1'b0;

    // Load-use hazard, several operand matches
    IDEX_MRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; IFID_Rt = 5'd0; #1;
    chk_ctl("lu_rs", 6'b001110);
    tick();
    IFID_Rs = 5'd3; IFID_Rt = 5'd5; #1;
    chk_ctl("lu_rt", 6'b001110);
    tick();
    IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0; #1;
    chk_ctl("lu_r0", 6'b111100);
    IDEX_MRead = 1'b0; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; #1;
    chk_ctl("lu_nold", 6'b111100);
    tick();

    // Load with ack after 4 wait cycles; hazard present during the memop stall
    MReadreg = 1'b1; ALUreg = 32'h0000_0100; IDEX_MRead = 1'b1; #1;
    chk_ctl("ld_idle", 6'b000001);
    tick();
    IDEX_MRead = 1'b0;
    chk("ld_req", {31'd0, mem_req}, 32'd1);
    chk("ld_addr", mem_addr, 32'h0000_0100);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_ctl("ld_wait", 6'b000001);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk_ctl("ld_ackcyc", 6'b000001);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'd0; MReadreg = 1'b0;
    chk_ctl("ld_done", 6'b111100);
    chk("ld_data", load_data, 32'hDEAD_BEEF);
    chk("ld_req_off", {31'd0, mem_req}, 32'd0);
    tick();
    chk_ctl("ld_idle_after", 6'b111100);

    // Store acked in first ACCESS cycle
    MWritereg = 1'b1; WriteDataOut = 32'h1234_5678; ALUreg = 32'h0000_0200; #1;
    chk_ctl("st_idle", 6'b000001);
    tick();
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    chk("st_addr", mem_addr, 32'h0000_0200);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    chk_ctl("st_access", 6'b000001);
    tick();
    mem_ack = 1'b0; MWritereg = 1'b0;
    chk_ctl("st_done", 6'b111100);
    chk("st_ld_keep", load_data, 32'hDEAD_BEEF);
    tick();

    // Ack arriving on the timeout cycle wins
    MReadreg = 1'b1; ALUreg = 32'h0000_0400;
    tick();
    for (int i = 0; i < 7; i++) tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; MReadreg = 1'b0;
    chk("sim_err", {31'd0, mem_err}, 32'd0);
    chk("sim_data", load_data, 32'hCAFE_F00D);
    chk_ctl("sim_done", 6'b111100);
    tick();

    // Timeout with no ack
    MReadreg = 1'b1; ALUreg = 32'h0000_0300;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("to_err_pre", {31'd0, mem_err}, 32'd0);
      chk_ctl("to_wait", 6'b000001);
      tick();
    end
    MReadreg = 1'b0;
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_data", load_data, 32'd0);
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk_ctl("to_done", 6'b111100);
    tick();

    // Successful store afterwards leaves mem_err set; back-to-back op restarts
    MWritereg = 1'b1; ALUreg = 32'h0000_0500; WriteDataOut = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("err_sticky", {31'd0, mem_err}, 32'd1);
    chk_ctl("b2b_done", 6'b111100);
    tick();
    chk_ctl("b2b_idle", 6'b000001);
    tick();
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-ACCESS (counter=5)
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; MWritereg = 1'b0; #1;
    chk_ctl("mid_rst_ctl", 6'b111100);
    tick();
    chk("mid_req_off", {31'd0, mem_req}, 32'd0);
    chk("mid_we", {31'd0, mem_we}, 32'd0);
    chk("mid_err", {31'd0, mem_err}, 32'd0);
    chk("mid_addr", mem_addr, 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111; #1;
    chk_ctl("late_ack_ctl", 6'b111100);
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ld", load_data, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk_ctl("late_ack_idle", 6'b111100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
Pipeline sequencing controller for the MIPS-style 5-stage core. It drives the per-stage write enables (PC, IF/ID, ID/EX, EX/MEM) and bubble controls. It runs the req/ack handshake to the multi-cycle data memory for loads and stores held in the EX/MEM register, and it detects load-use hazards between ID/EX and IF/ID. It sits between the EX/MEM register outputs, the data memory port and the hazard inputs from the decode stage.

Parameters:
TIMEOUT, 255, max cycles in ACCESS waiting for mem_ack before abort (1..65535)
CNT_W, 16, width of wait counter

Ports:
clock  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
MReadreg  in  1  EX/MEM holds a load
MWritereg  in  1  EX/MEM holds a store
ALUreg  in  32  EX/MEM address
WriteDataOut  in  32  EX/MEM store data
mem_ack  in  1  data memory completion, 1-cycle pulse
mem_rdata  in  32  data memory read data, valid with mem_ack
IDEX_MRead  in  1  ID/EX holds a load
IDEX_Rt  in  5  ID/EX load destination
IFID_Rs  in  5  IF/ID source 1
IFID_Rt  in  5  IF/ID source 2
mem_req  out  1  memory request, registered
mem_we  out  1  1=write, registered, valid with mem_req
mem_addr  out  32  registered address
mem_wdata  out  32  registered store data
load_data  out  32  captured read data for the MEM/WB register
PCWrite  out  1  PC enable
IFIDWrite  out  1  IF/ID enable
IDEXWrite  out  1  ID/EX enable
EXMEMWrite  out  1  EX/MEM enable
IDEX_flush  out  1  load ID/EX with a bubble
MEMWB_bubble  out  1  MEM/WB captures a bubble this cycle
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, on rising clock with rst=1): state=IDLE; counter=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load_data=0, mem_err=0. While rst=1, all enables=1, IDEX_flush=0 and MEMWB_bubble=0 combinationally. rst wins over every other event, including mid-ACCESS. A pending request is dropped, and a mem_ack arriving after reset is ignored in IDLE.
- memop = MReadreg | MWritereg.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, memop=1:
  - Stall: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, MEMWB_bubble=1.
  - Register mem_addr<=ALUreg, mem_wdata<=WriteDataOut, mem_we<=MWritereg, mem_req<=1, counter<=0.
  - Next state ACCESS.
  - If MReadreg and MWritereg are both 1, the op is treated as a store.
- IDLE, memop=0: no memory stall. Load-use hazard applies (below).
- ACCESS:
  - Stall as in IDLE; mem_req stays 1; counter increments.
  - mem_ack=1: load_data<=mem_rdata if !mem_we, else load_data unchanged. mem_req<=0, next state DONE.
  - counter==TIMEOUT-1 with no ack: mem_err<=1, load_data<=0, mem_req<=0, next state DONE.
  - mem_ack wins over timeout in the same cycle.
- DONE: all enables=1, MEMWB_bubble=0, and the completed op advances into MEM/WB with load_data. Next state is IDLE. A back-to-back memory op seen next cycle starts a new access.
- Minimum memory-op cost: 3 cycles (IDLE detect, 1 ACCESS, DONE).
- Load-use hazard (state IDLE, memop=0 only):
  - Condition: IDEX_MRead & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | IDEX_Rt==IFID_Rt).
  - Response: PCWrite=IFIDWrite=0, IDEX_flush=1, IDEXWrite=1, EXMEMWrite=1.
- Memory stall has priority over the hazard; IDEX_flush=0 in ACCESS/DONE and during the IDLE memop stall. The hazard is re-evaluated once in IDLE.
- Enables and flush are combinational from state and inputs. All other outputs are registered.
- mem_err clears only on rst.
- mem_ack while not in ACCESS is ignored.

Test Plan:
- Reset mid-ACCESS (mem_req=1, counter=5), rst=1 one cycle → next cycle mem_req=0, state IDLE, all enables 1. A late mem_ack the following cycle changes nothing.
- Load: MReadreg=1, ALUreg=0x100, ack after 4 cycles with mem_rdata=0xDEADBEEF → mem_addr=0x100 and mem_we=0 one cycle after detect. Enables 0 for 6 cycles (IDLE + 4 ACCESS + ack cycle), then high one cycle in DONE. load_data=0xDEADBEEF.
- Store: MWritereg=1, WriteDataOut=0x12345678, ack in 1st ACCESS cycle → mem_we=1, mem_wdata=0x12345678, load_data unchanged, total stall 2 cycles, EXMEMWrite=1 in DONE.
- Load-use: IDEX_MRead=1, IDEX_Rt=5, IFID_Rs=5, memop=0 → PCWrite=0, IFIDWrite=0, IDEX_flush=1. Repeat with IDEX_Rt=0 → no stall.
- Timeout with TIMEOUT=8, no ack → mem_err=1 after 8 ACCESS cycles, load_data=0, DONE reached. A later successful access leaves mem_err=1.
- Simultaneous events: ack arriving in the timeout cycle → no mem_err, load_data=mem_rdata. Load-use condition during an IDLE memop stall → IDEX_flush=0.
